// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_pkg
// Purpose  : Shared definitions for the byte-wide RAM arbiter (mem_ctrl):
//            FSM state encodings, mem_len transfer-size codes and byte-lane
//            helper functions.
// Config   : MEM_CTRL_FETCH_BUF_EN (consumed by mem_ctrl / mem_ctrl_fetch_buf)
// Revision : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_STORE = 2'd3
    } state_e;

    // mem_len codes are the index of the last byte of the transfer
    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd3;

    // Little-endian lane k occupies bits [8k+7:8k]
    function automatic logic [31:0] put_byte(input logic [31:0] w,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = w;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] w,
                                            input logic [1:0]  idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_fetch_buf
// Purpose  : One-entry fetch buffer (valid, tag address, word) that lets a
//            repeated fetch of the same address complete without RAM access.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            lookup_addr_i    - address of the pending fetch
//            hit_o / word_o   - tag match on a valid entry / buffered word
//            fill_i, fill_addr_i, fill_word_i - refill on fetch completion
//            inv_i            - invalidate (accepted store)
// Config   : only present when MEM_CTRL_FETCH_BUF_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
`ifdef MEM_CTRL_FETCH_BUF_EN
module mem_ctrl_fetch_buf
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookup_addr_i,
    output logic        hit_o,
    output logic [31:0] word_o,
    input  logic        fill_i,
    input  logic [31:0] fill_addr_i,
    input  logic [31:0] fill_word_i,
    input  logic        inv_i
);

    logic        valid_q, valid_d;
    logic [31:0] tag_q, tag_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        word_d  = word_q;
        // A store may alias the buffered word, so invalidation wins
        if (inv_i) begin
            valid_d = 1'b0;
        end else if (fill_i) begin
            valid_d = 1'b1;
            tag_d   = fill_addr_i;
            word_d  = fill_word_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            word_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            word_q  <= word_d;
        end
    end

    assign hit_o  = valid_q && (tag_q == lookup_addr_i);
    assign word_o = word_q;

endmodule
`endif
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Arbitrates one byte-wide synchronous RAM port between the
//            instruction fetch (always 4 bytes) and load/store (1/2/4 bytes),
//            little-endian, one byte per cycle. Load/store wins in IDLE;
//            transfers are never preempted; a branch flush aborts a fetch.
// Ports    : clk, rst                      - clock, sync active-high reset
//            if_req/if_addr/if_data/if_done - fetch interface
//            mem_req/mem_we/mem_addr/mem_wdata/mem_len/mem_rdata/mem_done
//                                          - load/store interface
//            ex_b_flag                     - branch-taken flush
//            ram_addr/ram_dout/ram_we/ram_din - RAM port (read data valid
//                                            one cycle after its address)
//            stallreq_if/stallreq_mem      - stall requests
// Config   : MEM_CTRL_FETCH_BUF_EN adds a one-entry fetch buffer
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_data,
    output logic        if_done,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [1:0]  mem_len,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    input  logic        ex_b_flag,
    output logic [31:0] ram_addr,
    output logic [7:0]  ram_dout,
    output logic        ram_we,
    input  logic [7:0]  ram_din,
    output logic        stallreq_if,
    output logic        stallreq_mem
);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;         // index of byte currently on ram_addr
    logic        iss_q, iss_d;         // read addresses still being issued
    logic        rx_vld_q, rx_vld_d;   // ram_din carries a requested byte
    logic [1:0]  rx_idx_q, rx_idx_d;   // which byte ram_din carries
    logic [1:0]  last_q, last_d;       // index of the final byte
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] acc_q, acc_d;         // read assembly register
    logic [31:0] ram_addr_q, addr_d;
    logic [7:0]  ram_dout_q, dout_d;
    logic        ram_we_q, we_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_done_q, if_done_d;
    logic        mem_done_q, mem_done_d;

    logic [31:0] w_word;
    logic        w_buf_hit;
    logic [31:0] w_buf_word;
    logic        w_hit;

`ifdef MEM_CTRL_FETCH_BUF_EN
    logic w_buf_fill;
    logic w_buf_inv;

    assign w_buf_fill = (state_q == ST_FETCH) && if_done_d;
    assign w_buf_inv  = (state_q == ST_IDLE) && (state_d == ST_STORE);

    // At fetch completion ram_addr still holds addr+3, so the tag is
    // recovered by subtracting 3 (mod 2^32, matching the wrapped issue).
    mem_ctrl_fetch_buf u_fetch_buf (
        .clk           (clk),
        .rst           (rst),
        .lookup_addr_i (if_addr),
        .hit_o         (w_buf_hit),
        .word_o        (w_buf_word),
        .fill_i        (w_buf_fill),
        .fill_addr_i   (ram_addr_q - 32'd3),
        .fill_word_i   (if_data_d),
        .inv_i         (w_buf_inv)
    );
`else
    assign w_buf_hit  = 1'b0;
    assign w_buf_word = '0;
`endif

    // Buffer hits complete in IDLE without starting a RAM transfer
    assign w_hit  = (state_q == ST_IDLE) && if_req && !mem_req && !ex_b_flag && w_buf_hit;
    assign w_word = put_byte(acc_q, rx_idx_q, ram_din);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        iss_d       = iss_q;
        rx_vld_d    = 1'b0;
        rx_idx_d    = rx_idx_q;
        last_d      = last_q;
        wdata_d     = wdata_q;
        acc_d       = acc_q;
        addr_d      = ram_addr_q;
        dout_d      = ram_dout_q;
        we_d        = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    cnt_d   = '0;
                    last_d  = mem_len;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    acc_d   = '0;   // unused upper lanes read back as zero
                    if (mem_we) begin
                        state_d = ST_STORE;
                        we_d    = 1'b1;
                        dout_d  = mem_wdata[7:0];
                        iss_d   = 1'b0;
                    end else begin
                        state_d = ST_LOAD;
                        iss_d   = 1'b1;
                    end
                end else if (if_req && !ex_b_flag && !w_buf_hit) begin
                    state_d = ST_FETCH;
                    cnt_d   = '0;
                    last_d  = LEN_WORD;
                    addr_d  = if_addr;
                    acc_d   = '0;
                    iss_d   = 1'b1;
                end
            end

            ST_FETCH, ST_LOAD: begin
                if ((state_q == ST_FETCH) && ex_b_flag) begin
                    state_d = ST_IDLE;
                    iss_d   = 1'b0;
                end else begin
                    // Address issue runs one cycle ahead of data return
                    rx_vld_d = iss_q;
                    rx_idx_d = cnt_q;
                    if (iss_q) begin
                        if (cnt_q == last_q) begin
                            iss_d = 1'b0;
                        end else begin
                            cnt_d  = cnt_q + 2'd1;
                            addr_d = ram_addr_q + 32'd1;
                        end
                    end
                    if (rx_vld_q) begin
                        acc_d = w_word;
                        if (rx_idx_q == last_q) begin
                            state_d = ST_IDLE;
                            if (state_q == ST_FETCH) begin
                                if_data_d = w_word;
                                if_done_d = 1'b1;
                            end else begin
                                mem_rdata_d = w_word;
                                mem_done_d  = 1'b1;
                            end
                        end
                    end
                end
            end

            ST_STORE: begin
                if (cnt_q == last_q) begin
                    state_d    = ST_IDLE;
                    mem_done_d = 1'b1;
                end else begin
                    we_d   = 1'b1;
                    cnt_d  = cnt_q + 2'd1;
                    addr_d = ram_addr_q + 32'd1;
                    dout_d = get_byte(wdata_q, cnt_q + 2'd1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            iss_q       <= 1'b0;
            rx_vld_q    <= 1'b0;
            rx_idx_q    <= '0;
            last_q      <= '0;
            wdata_q     <= '0;
            acc_q       <= '0;
            ram_addr_q  <= '0;
            ram_dout_q  <= '0;
            ram_we_q    <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            iss_q       <= iss_d;
            rx_vld_q    <= rx_vld_d;
            rx_idx_q    <= rx_idx_d;
            last_q      <= last_d;
            wdata_q     <= wdata_d;
            acc_q       <= acc_d;
            ram_addr_q  <= addr_d;
            ram_dout_q  <= dout_d;
            ram_we_q    <= we_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    assign ram_addr     = ram_addr_q;
    assign ram_dout     = ram_dout_q;
    assign ram_we       = ram_we_q;
    assign if_data      = w_hit ? w_buf_word : if_data_q;
    assign if_done      = if_done_q | w_hit;
    assign mem_rdata    = mem_rdata_q;
    assign mem_done     = mem_done_q;
    assign stallreq_if  = if_req & ~if_done;
    assign stallreq_mem = mem_req & ~mem_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Directed self-checking bench for mem_ctrl with a byte-wide
//            synchronous RAM model (read data one cycle after address).
// Config   : MEM_CTRL_FETCH_BUF_EN selects the fetch-buffer checks
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_len;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        ex_b_flag;
    logic [31:0] ram_addr;
    logic [7:0]  ram_dout;
    logic        ram_we;
    logic [7:0]  ram_din;
    logic        stallreq_if;
    logic        stallreq_mem;

    int n_chk;
    int n_fail;

    mem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_data      (if_data),
        .if_done      (if_done),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_len      (mem_len),
        .mem_rdata    (mem_rdata),
        .mem_done     (mem_done),
        .ex_b_flag    (ex_b_flag),
        .ram_addr     (ram_addr),
        .ram_dout     (ram_dout),
        .ram_we       (ram_we),
        .ram_din      (ram_din),
        .stallreq_if  (stallreq_if),
        .stallreq_mem (stallreq_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: preset contents come from init_byte until a byte is written
    bit [7:0] ram_mem [0:4095];
    bit       ram_wr  [0:4095];

    function automatic logic [7:0] init_byte(input logic [11:0] a);
        case (a)
            12'h100: return 8'h13;
            12'h101: return 8'h05;
            12'h104: return 8'h93;
            12'h106: return 8'h10;
            12'h200: return 8'h11;
            12'h201: return 8'h22;
            12'h202: return 8'h33;
            12'h203: return 8'h44;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_addr[11:0]] <= ram_dout;
            ram_wr[ram_addr[11:0]]  <= 1'b1;
        end
        ram_din <= ram_wr[ram_addr[11:0]] ? ram_mem[ram_addr[11:0]] : init_byte(ram_addr[11:0]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts cycles from the acceptance edge until the selected done pulse
    task automatic wait_done(input bit use_mem, output int cyc);
        cyc = 0;
        while (((use_mem ? mem_done : if_done) !== 1'b1) && (cyc < 20)) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int ndone;
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_len   = 2'd0;
        ex_b_flag = 1'b0;

        // ---- reset state
        tick();
        tick();
        chk("rst_ram_addr", ram_addr, 32'h0);
        chk("rst_ram_dout", {24'h0, ram_dout}, 32'h0);
        chk("rst_ram_we", {31'h0, ram_we}, 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_dones", {30'h0, if_done, mem_done}, 32'h0);
        rst = 1'b0;
        tick();

        // ---- basic fetch
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        chk("fetch_addr0", ram_addr, 32'h100);
        chk("fetch_stall", {31'h0, stallreq_if}, 32'h1);
        wait_done(1'b0, cyc);
        chk("fetch_latency", cyc, 5);
        chk("fetch_data", if_data, 32'h00000513);
        chk("fetch_stall_clr", {31'h0, stallreq_if}, 32'h0);
        if_req = 1'b0;
        tick();

        // ---- contention: load wins, fetch follows
        if_req = 1'b1; if_addr = 32'h104;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200; mem_len = 2'd3;
        tick();
        chk("cont_load_first", ram_addr, 32'h200);
        wait_done(1'b1, cyc);
        chk("cont_load_lat", cyc, 5);
        chk("cont_load_data", mem_rdata, 32'h44332211);
        chk("cont_if_stall", {31'h0, stallreq_if}, 32'h1);
        mem_req = 1'b0;
        tick();
        chk("cont_fetch_start", ram_addr, 32'h104);
        wait_done(1'b0, cyc);
        chk("cont_fetch_lat", cyc, 5);
        chk("cont_fetch_data", if_data, 32'h00100093);
        if_req = 1'b0;

        // ---- byte and halfword loads, zero-extended
        mem_req = 1'b1; mem_addr = 32'h203; mem_len = 2'd0;
        tick();
        wait_done(1'b1, cyc);
        chk("ldb_lat", cyc, 2);
        chk("ldb_data", mem_rdata, 32'h00000044);
        mem_addr = 32'h201; mem_len = 2'd1;
        tick();
        tick();
        wait_done(1'b1, cyc);
        chk("ldh_lat", cyc, 2);
        chk("ldh_data", mem_rdata, 32'h00003322);
        mem_req = 1'b0;
        tick();

        // ---- halfword store
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h300; mem_len = 2'd1; mem_wdata = 32'hAABBCCDD;
        tick();
        chk("st_b0", {ram_we, 15'h0, ram_addr[7:0], ram_dout}, {1'b1, 15'h0, 8'h00, 8'hDD});
        chk("st_b0_addr", ram_addr, 32'h300);
        tick();
        chk("st_b1", {ram_we, 15'h0, ram_addr[7:0], ram_dout}, {1'b1, 15'h0, 8'h01, 8'hCC});
        chk("st_done_early", {31'h0, mem_done}, 32'h0);
        tick();
        chk("st_done", {30'h0, ram_we, mem_done}, 32'h1);
        mem_req = 1'b0; mem_we = 1'b0;
        tick();
        mem_req = 1'b1; mem_addr = 32'h300; mem_len = 2'd3;
        tick();
        wait_done(1'b1, cyc);
        chk("st_readback", mem_rdata, 32'h0000CCDD);
        mem_req = 1'b0;
        tick();

        // ---- flush in the second fetch cycle, flush blocks acceptance
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        tick();
        ex_b_flag = 1'b1;
        tick();
        chk("flush_addr_hold", ram_addr, 32'h101);
        chk("flush_no_done", {31'h0, if_done}, 32'h0);
        chk("flush_if_data", if_data, 32'h00100093);
        tick();
        chk("flush_no_accept", ram_addr, 32'h101);
        ex_b_flag = 1'b0;
        tick();
        chk("flush_refetch", ram_addr, 32'h100);
        wait_done(1'b0, cyc);
        chk("flush_refetch_lat", cyc, 5);
        chk("flush_refetch_data", if_data, 32'h00000513);
        if_req = 1'b0;
        tick();

        // ---- reset mid-load at byte 2
        mem_req = 1'b1; mem_addr = 32'h200; mem_len = 2'd3;
        tick();
        tick();
        tick();
        chk("rstld_at_b2", ram_addr, 32'h202);
        rst = 1'b1; mem_req = 1'b0;
        tick();
        chk("rstld_addr", ram_addr, 32'h0);
        chk("rstld_data", {if_data | mem_rdata}, 32'h0);
        chk("rstld_misc", {22'h0, ram_dout, ram_we, mem_done}, 32'h0);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mem_done === 1'b1) ndone++;
        end
        chk("rstld_no_done", ndone, 0);

        // ---- repeat fetch (buffered or not)
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        wait_done(1'b0, cyc);
        chk("rep_fetch1_lat", cyc, 5);
        if_req = 1'b0;
        tick();
`ifdef MEM_CTRL_FETCH_BUF_EN
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        chk("buf_hit_done", {31'h0, if_done}, 32'h1);
        chk("buf_hit_data", if_data, 32'h00000513);
        chk("buf_hit_stall", {31'h0, stallreq_if}, 32'h0);
        tick();
        if_req = 1'b0;
        tick();
        chk("buf_no_ram", ram_addr, 32'h103);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h3F0; mem_len = 2'd0; mem_wdata = 32'h5A;
        tick();
        wait_done(1'b1, cyc);
        chk("buf_store_lat", cyc, 1);
        mem_req = 1'b0; mem_we = 1'b0;
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        chk("buf_inv_miss", {31'h0, if_done}, 32'h0);
        tick();
        chk("buf_refetch_start", ram_addr, 32'h100);
        wait_done(1'b0, cyc);
        chk("buf_refetch_lat", cyc, 5);
        if_req = 1'b0;
`else
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        chk("rep_fetch2_start", ram_addr, 32'h100);
        wait_done(1'b0, cyc);
        chk("rep_fetch2_lat", cyc, 5);
        chk("rep_fetch2_data", if_data, 32'h00000513);
        if_req = 1'b0;
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: if_req in 1 fetch request; if_addr in 32 fetch byte address; if_data out 32 fetched word; if_done out 1 one-cycle completion pulse.
REQ-004 SHALL have ports: mem_req in 1 load/store request; mem_we in 1 (1=store); mem_addr in 32; mem_wdata in 32; mem_len in 2 (0=1B, 1=2B, 3=4B); mem_rdata out 32 zero-extended; mem_done out 1 pulse.
REQ-005 SHALL have ports: ex_b_flag in 1 branch-taken flush.
REQ-006 SHALL have ports: ram_addr out 32; ram_dout out 8; ram_we out 1; ram_din in 8 (RAM read data valid one cycle after its address).
REQ-007 SHALL have ports: stallreq_if out 1; stallreq_mem out 1, feeding the pipeline stall controller.

Function
REQ-008 SHALL arbitrate one byte-wide RAM port between fetch and load/store with FSM states IDLE, FETCH, LOAD, STORE.
REQ-009 In IDLE, mem_req SHALL win over if_req; the accepted request is latched (addr, len, wdata) at acceptance.
REQ-010 A started transfer SHALL NOT be preempted; the losing requester waits until the winner returns to IDLE.
REQ-011 Byte order SHALL be little-endian: byte k at addr+k maps to bits [8k+7:8k].
REQ-012 Read of n bytes: addresses addr..addr+n-1 on consecutive cycles after acceptance; done pulse n+1 cycles after the acceptance edge; data registered.
REQ-013 Write of n bytes: ram_we=1 with one byte per cycle for n cycles; mem_done pulses in the cycle after the last byte.
REQ-014 FETCH SHALL always be 4 bytes; mem_len ignored for fetch.
REQ-015 After a done pulse the FSM SHALL return to IDLE and may accept a new request the next cycle.
REQ-016 stallreq_if = if_req AND NOT if_done; stallreq_mem = mem_req AND NOT mem_done.
REQ-017 ex_b_flag during FETCH SHALL abort it: IDLE next cycle, no if_done, if_data unchanged; ex_b_flag SHALL NOT affect LOAD/STORE.
REQ-018 ex_b_flag and if_req simultaneous in IDLE: fetch SHALL NOT be accepted that cycle.
REQ-019 Byte counter SHALL be 2 bits and address increments SHALL wrap modulo 2^32.
REQ-020 ram_we SHALL be 0 whenever not in STORE.

Reset
REQ-021 On rst: state IDLE, counter 0, ram_we 0, ram_addr 0, ram_dout 0, if_data 0, mem_rdata 0, if_done 0, mem_done 0.
REQ-022 rst mid-transfer SHALL discard it with no done pulse; a partially written store is not rolled back.

Configuration
REQ-023 Macro MEM_CTRL_FETCH_BUF_EN SHALL add a one-entry fetch buffer (valid, tag addr, word).
REQ-024 With MEM_CTRL_FETCH_BUF_EN: in IDLE, an if_req whose address equals the valid tag, with no mem_req, SHALL pulse if_done in the same cycle with the buffered word and no RAM access; each completed fetch refills the buffer; any accepted store and rst clear valid.
REQ-025 Without MEM_CTRL_FETCH_BUF_EN: every fetch SHALL use the RAM per REQ-012 and no buffer storage is synthesized.

Structure
REQ-026 FSM state encodings and mem_len codes SHALL live in the shared defines header.
REQ-027 With MEM_CTRL_FETCH_BUF_EN, the buffer SHALL be sub-module mem_ctrl_fetch_buf; otherwise a single module.

Verification
REQ-028 Fetch: RAM[0x100..0x103]=13,05,00,00; if_req at 0x100 -> if_done 5 cycles after acceptance, if_data=0x00000513.
REQ-029 Contention: if_req and mem_req (load, len=3, 0x200) same cycle -> LOAD first, stallreq_if held high, FETCH begins the cycle after mem_done.
REQ-030 Store halfword: mem_wdata=0xAABBCCDD, len=1, addr 0x300 -> ram_we 2 cycles writing 0xDD@0x300, 0xCC@0x301; mem_done next cycle.
REQ-031 Flush: ex_b_flag in second FETCH cycle -> IDLE next cycle, no if_done, next fetch accepted normally.
REQ-032 Reset mid-LOAD at byte 2 -> all outputs zero next cycle, no mem_done.
REQ-033 With MEM_CTRL_FETCH_BUF_EN: repeat fetch 0x100 -> same-cycle if_done, no RAM addresses driven; after a store to any address, refetch takes 5 cycles.
